// File: rtl/sdcard_pkg.sv
// Shared definitions for the SD-card SPI transfer engine and its CRC unit.
// Mode encodings select single exchange, burst write, response poll or token-wait read.
// Holds the CRC-CCITT polynomial and the engine state encoding.
package sdcard_pkg;

  localparam logic [1:0] MODE_SINGLE   = 2'd0;
  localparam logic [1:0] MODE_BURST_WR = 2'd1;
  localparam logic [1:0] MODE_POLL     = 2'd2;
  localparam logic [1:0] MODE_TOKEN_RD = 2'd3;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POLL = 2'd1,
    ST_XFER = 2'd2
  } state_t;

endpackage

// File: rtl/sdcard_crc16.sv
// Bit-serial CRC-CCITT (x^16+x^12+x^5+1, init 0), one bit per enabled cycle.
// Latency: crc_o reflects an accepted bit one clk cycle after en_i.
// No backpressure: every enabled cycle consumes bit_i; clear_i has priority.
module sdcard_crc16
  import sdcard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic        fb;

  assign fb    = crc_q[15] ^ bit_i;
  assign crc_o = crc_q;

  // Next CRC value: clear wins, otherwise shift in one bit when enabled.
  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

  // CRC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

endmodule

// File: rtl/sdcard_spi_xfer.sv
// SD-card SPI mode-0 transfer engine: single word, burst write, response poll, token-wait read.
// Latency: first SCLK rise max(divider,1) clk cycles after start; rx_valid on the word's last falling edge.
// Upstream must present the next tx word within one word time of tx_req; no other backpressure.
module sdcard_spi_xfer
  import sdcard_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  parameter int CNT_W  = 10,
  parameter int POLL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  input  logic [DIV_W-1:0]  divider,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  count,
  input  logic [POLL_W-1:0] poll_max,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              start,
  input  logic              abort,
  output logic              tx_req,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              finished,
  output logic              timeout,
  output logic [15:0]       crc16,
  output logic              crc_bit,
  output logic              crc_strobe
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [POLL_W-1:0] poll_max_q, poll_max_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              miso_q, miso_d;
  // tx_sr holds the bits still to be sent after the one on mosi.
  logic [DATA_W-2:0] tx_sr_q, tx_sr_d;
  // rx_sr holds the most recent DATA_W-1 received bits; the current bit completes the word.
  logic [DATA_W-2:0] rx_sr_q, rx_sr_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              timeout_q, timeout_d;
  logic              crc_bit_q, crc_bit_d;
  logic              tx_req_q, tx_req_d;
  logic              rx_valid_q, rx_valid_d;
  logic              finished_q, finished_d;
  logic              crc_strobe_q, crc_strobe_d;

  logic              crc_clr, crc_en, crc_in;
  logic [DIV_W-1:0]  div_eff;
  logic              sclk_tick;
  logic [DATA_W-1:0] rx_word;
  logic              poll_last;
  logic              word_done;
  logic              more_words;
  logic              data_bit;

  // A zero divider behaves as one; compare with >= so a shrinking divider still ends the half-period.
  assign div_eff    = (divider == '0) ? DIV_W'(1) : divider;
  assign sclk_tick  = (div_cnt_q >= (div_eff - DIV_W'(1)));
  assign rx_word    = {rx_sr_q, miso_q};
  assign poll_last  = (poll_cnt_q == poll_max_q);
  assign word_done  = (bit_cnt_q == BIT_LAST);
  assign more_words = (mode_q != MODE_SINGLE) && (word_cnt_q != count_q);
  // Write modes expose the transmitted bit, read modes the received bit.
  assign data_bit   = mode_q[1] ? miso_q : mosi_q;

  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign busy       = (state_q != ST_IDLE);
  assign rx_data    = rx_data_q;
  assign timeout    = timeout_q;
  assign tx_req     = tx_req_q;
  assign rx_valid   = rx_valid_q;
  assign finished   = finished_q;
  assign crc_bit    = crc_bit_q;
  assign crc_strobe = crc_strobe_q;

  // Next-state and datapath: SCLK divider, bit shifting, word/poll accounting.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    count_d      = count_q;
    poll_max_d   = poll_max_q;
    div_cnt_d    = div_cnt_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    miso_d       = miso_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    poll_cnt_d   = poll_cnt_q;
    rx_data_d    = rx_data_q;
    timeout_d    = timeout_q;
    crc_bit_d    = crc_bit_q;
    tx_req_d     = 1'b0;
    rx_valid_d   = 1'b0;
    finished_d   = 1'b0;
    crc_strobe_d = 1'b0;
    crc_clr      = 1'b0;
    crc_en       = 1'b0;
    crc_in       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sclk_d    = 1'b0;
        mosi_d    = 1'b1;
        div_cnt_d = '0;
        if (start && !abort) begin
          mode_d     = mode;
          count_d    = count;
          poll_max_d = poll_max;
          timeout_d  = 1'b0;
          crc_clr    = 1'b1;
          rx_sr_d    = '1;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          poll_cnt_d = '0;
          if (!mode[1]) begin
            tx_sr_d  = tx_data[DATA_W-2:0];
            mosi_d   = tx_data[DATA_W-1];
            tx_req_d = 1'b1;
            state_d  = ST_XFER;
          end else begin
            tx_sr_d = '1;
            state_d = ST_POLL;
          end
        end
      end

      ST_POLL, ST_XFER: begin
        if (abort) begin
          state_d   = ST_IDLE;
          sclk_d    = 1'b0;
          mosi_d    = 1'b1;
          div_cnt_d = '0;
        end else if (!sclk_tick) begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end else begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          if (!sclk_q) begin
            // Rising edge: sample the card.
            miso_d = miso;
          end else begin
            // Falling edge: shift in the sampled bit and move on.
            rx_sr_d = rx_word[DATA_W-2:0];
            if (state_q == ST_POLL) begin
              poll_cnt_d = poll_cnt_q + POLL_W'(1);
              if (mode_q == MODE_POLL) begin
                crc_strobe_d = 1'b1;
                crc_bit_d    = miso_q;
              end
              if (mode_q == MODE_POLL && !rx_word[DATA_W-1]) begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
                finished_d = 1'b1;
                mosi_d     = 1'b1;
                state_d    = ST_IDLE;
              end else if (mode_q == MODE_TOKEN_RD && !miso_q) begin
                // Start token seen: data words follow immediately.
                bit_cnt_d  = '0;
                word_cnt_d = '0;
                tx_sr_d    = '1;
                mosi_d     = 1'b1;
                state_d    = ST_XFER;
              end else if (poll_last) begin
                timeout_d  = 1'b1;
                rx_data_d  = rx_word;
                finished_d = 1'b1;
                mosi_d     = 1'b1;
                state_d    = ST_IDLE;
              end
            end else begin
              crc_strobe_d = 1'b1;
              crc_bit_d    = data_bit;
              crc_en       = (mode_q == MODE_BURST_WR) || (mode_q == MODE_TOKEN_RD);
              crc_in       = data_bit;
              mosi_d       = tx_sr_q[DATA_W-2];
              tx_sr_d      = {tx_sr_q[DATA_W-3:0], 1'b1};
              if (!word_done) begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
              end else begin
                bit_cnt_d  = '0;
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
                if (more_words) begin
                  word_cnt_d = word_cnt_q + CNT_W'(1);
                  if (mode_q == MODE_BURST_WR) begin
                    tx_sr_d  = tx_data[DATA_W-2:0];
                    mosi_d   = tx_data[DATA_W-1];
                    tx_req_d = 1'b1;
                  end else begin
                    tx_sr_d = '1;
                    mosi_d  = 1'b1;
                  end
                end else begin
                  finished_d = 1'b1;
                  mosi_d     = 1'b1;
                  state_d    = ST_IDLE;
                end
              end
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        sclk_d  = 1'b0;
        mosi_d  = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset leaves the bus idle (SCLK low, MOSI high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_SINGLE;
      count_q      <= '0;
      poll_max_q   <= '0;
      div_cnt_q    <= '0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b1;
      miso_q       <= 1'b1;
      tx_sr_q      <= '1;
      rx_sr_q      <= '1;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      poll_cnt_q   <= '0;
      rx_data_q    <= '0;
      timeout_q    <= 1'b0;
      crc_bit_q    <= 1'b0;
      tx_req_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      finished_q   <= 1'b0;
      crc_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      count_q      <= count_d;
      poll_max_q   <= poll_max_d;
      div_cnt_q    <= div_cnt_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      miso_q       <= miso_d;
      tx_sr_q      <= tx_sr_d;
      rx_sr_q      <= rx_sr_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      poll_cnt_q   <= poll_cnt_d;
      rx_data_q    <= rx_data_d;
      timeout_q    <= timeout_d;
      crc_bit_q    <= crc_bit_d;
      tx_req_q     <= tx_req_d;
      rx_valid_q   <= rx_valid_d;
      finished_q   <= finished_d;
      crc_strobe_q <= crc_strobe_d;
    end
  end

  // CRC16 over data-phase bits of burst transfers.
  sdcard_crc16 u_crc16 (
    .clk     (clk),
    .rst     (rst),
    .clear_i (crc_clr),
    .en_i    (crc_en),
    .bit_i   (crc_in),
    .crc_o   (crc16)
  );

endmodule

// File: tb/tb_sdcard_spi_xfer.sv
// Directed bench for the SD-card SPI transfer engine.
// Card side is a bit table replayed one bit per SCLK falling edge, or MOSI loopback.
// A clk-synchronous monitor counts SCLK edges and output pulses for the scenario tasks.
module tb_sdcard_spi_xfer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk, mosi, miso;
  logic [7:0]  divider = 8'd0;
  logic [1:0]  mode = 2'd0;
  logic [9:0]  count = 10'd0;
  logic [15:0] poll_max = 16'd0;
  logic [7:0]  tx_data = 8'd0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        tx_req, rx_valid, busy, finished, timeout, crc_bit, crc_strobe;
  logic [7:0]  rx_data;
  logic [15:0] crc16;

  int checks = 0;
  int errors = 0;

  // Monitor state
  int cyc = 0, rise_cnt = 0, fall_cnt = 0, txreq_cnt = 0, rxv_cnt = 0, fin_cnt = 0;
  int strobe_cnt = 0, rxv_not_ff = 0, mosi_low_cnt = 0;
  int last_rise_cyc = 0, last_fall_cyc = 0, last_rxv_cyc = 0, last_fin_cyc = 0;
  logic        sclk_prev = 1'b0;
  logic [31:0] mosi_hist = 32'd0;

  // Card model: bit table indexed by falling edges since the scenario began.
  logic        loop_en = 1'b0;
  logic        miso_bits [0:8191];
  int          miso_len = 0;
  int          miso_base = 0;
  logic [12:0] midx;
  assign midx = 13'(fall_cnt - miso_base);
  assign miso = loop_en ? mosi : ((int'(midx) < miso_len) ? miso_bits[midx] : 1'b1);

  always #5 clk = ~clk;

  sdcard_spi_xfer dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .miso(miso),
    .divider(divider), .mode(mode), .count(count), .poll_max(poll_max),
    .tx_data(tx_data), .start(start), .abort(abort), .tx_req(tx_req),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .finished(finished),
    .timeout(timeout), .crc16(crc16), .crc_bit(crc_bit), .crc_strobe(crc_strobe)
  );

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (sclk && !sclk_prev) begin
      rise_cnt = rise_cnt + 1;
      last_rise_cyc = cyc;
      mosi_hist = {mosi_hist[30:0], mosi};
    end
    if (!sclk && sclk_prev) begin
      fall_cnt = fall_cnt + 1;
      last_fall_cyc = cyc;
    end
    sclk_prev = sclk;
    if (tx_req) txreq_cnt = txreq_cnt + 1;
    if (rx_valid) begin
      rxv_cnt = rxv_cnt + 1;
      last_rxv_cyc = cyc;
      if (rx_data != 8'hFF) rxv_not_ff = rxv_not_ff + 1;
    end
    if (finished) begin
      fin_cnt = fin_cnt + 1;
      last_fin_cyc = cyc;
    end
    if (crc_strobe) strobe_cnt = strobe_cnt + 1;
    if (busy && !mosi) mosi_low_cnt = mosi_low_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load_bits(input logic [63:0] pat, input int n);
    for (int i = 0; i < n; i++) miso_bits[13'(i)] = pat[n-1-i];
    miso_len  = n;
    miso_base = fall_cnt;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_fin(input int f0, input int budget, input string nm);
    int n = 0;
    while (fin_cnt == f0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (fin_cnt == f0) begin
      errors++;
      $display("FAIL %s: finished not seen within %0d cycles", nm, budget);
    end
  endtask

  task automatic first_rise(output int k);
    k = 0;
    while (!sclk && k < 100) begin
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks += 7;
    if (sclk !== 1'b0)  begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    if (mosi !== 1'b1)  begin errors++; $display("FAIL reset_mosi: got %b want 1", mosi); end
    if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    if (crc16 !== 16'h0000) begin errors++; $display("FAIL reset_crc16: got %h want 0000", crc16); end
    if ({tx_req, rx_valid, finished, crc_strobe} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses: got %b want 0000", {tx_req, rx_valid, finished, crc_strobe});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int r0, f0, s0, k;
    loop_en = 1'b1; divider = 8'd0; mode = 2'd0; tx_data = 8'hA5;
    r0 = rise_cnt; f0 = fin_cnt; s0 = strobe_cnt;
    pulse_start();
    first_rise(k);
    checks++;
    if (k !== 1) begin errors++; $display("FAIL single_first_rise: got %0d want 1", k); end
    wait_fin(f0, 100, "single_done");
    step();
    checks += 8;
    if (rise_cnt - r0 !== 8) begin errors++; $display("FAIL single_rises: got %0d want 8", rise_cnt - r0); end
    if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_rx_data: got %h want a5", rx_data); end
    if (fin_cnt - f0 !== 1) begin errors++; $display("FAIL single_fin_count: got %0d want 1", fin_cnt - f0); end
    if (last_rxv_cyc !== last_fin_cyc) begin
      errors++; $display("FAIL single_rxv_with_fin: rx_valid cyc %0d finished cyc %0d", last_rxv_cyc, last_fin_cyc);
    end
    if (sclk !== 1'b0) begin errors++; $display("FAIL single_sclk_idle: got %b want 0", sclk); end
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
    if (mosi !== 1'b1) begin errors++; $display("FAIL single_mosi_idle: got %b want 1", mosi); end
    if (strobe_cnt - s0 !== 8) begin errors++; $display("FAIL single_strobes: got %0d want 8", strobe_cnt - s0); end
    loop_en = 1'b0;
  endtask

  task automatic test_poll_match();
    int r0, f0, v0, s0, k;
    divider = 8'd3; mode = 2'd2; poll_max = 16'd63;
    load_bits({43'd0, 13'h1FFF, 8'h01}, 21);
    r0 = rise_cnt; f0 = fin_cnt; v0 = rxv_cnt; s0 = strobe_cnt;
    pulse_start();
    first_rise(k);
    checks++;
    if (k !== 3) begin errors++; $display("FAIL poll_first_rise: got %0d want 3", k); end
    wait_fin(f0, 500, "poll_done");
    step();
    checks += 6;
    if (rise_cnt - r0 !== 21) begin errors++; $display("FAIL poll_bits: got %0d want 21", rise_cnt - r0); end
    if (rx_data !== 8'h01) begin errors++; $display("FAIL poll_rx_data: got %h want 01", rx_data); end
    if (rxv_cnt - v0 !== 1) begin errors++; $display("FAIL poll_rx_valid: got %0d want 1", rxv_cnt - v0); end
    if (timeout !== 1'b0) begin errors++; $display("FAIL poll_timeout: got %b want 0", timeout); end
    if (last_fall_cyc - last_rise_cyc !== 3) begin
      errors++; $display("FAIL poll_half_period: got %0d want 3", last_fall_cyc - last_rise_cyc);
    end
    if (strobe_cnt - s0 !== 21) begin errors++; $display("FAIL poll_strobes: got %0d want 21", strobe_cnt - s0); end
  endtask

  task automatic test_abort();
    int f0, v0;
    divider = 8'd1; mode = 2'd2; poll_max = 16'd63;
    load_bits(64'd0, 0);
    f0 = fin_cnt; v0 = rxv_cnt;
    pulse_start();
    repeat (20) step();
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    if (sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b want 0", sclk); end
    if (mosi !== 1'b1) begin errors++; $display("FAIL abort_mosi: got %b want 1", mosi); end
    repeat (5) step();
    checks += 4;
    if (fin_cnt - f0 !== 0) begin errors++; $display("FAIL abort_no_fin: got %0d want 0", fin_cnt - f0); end
    if (rxv_cnt - v0 !== 0) begin errors++; $display("FAIL abort_no_rxv: got %0d want 0", rxv_cnt - v0); end
    if (rx_data !== 8'h01) begin errors++; $display("FAIL abort_rx_kept: got %h want 01", rx_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_ignored: busy %b want 0", busy); end
  endtask

  task automatic test_poll_timeout();
    int r0, f0, v0;
    divider = 8'd1; mode = 2'd2; poll_max = 16'd15;
    load_bits(64'd0, 0);
    r0 = rise_cnt; f0 = fin_cnt; v0 = rxv_cnt;
    pulse_start();
    wait_fin(f0, 200, "timeout_done");
    repeat (3) step();
    checks += 5;
    if (rise_cnt - r0 !== 16) begin errors++; $display("FAIL timeout_bits: got %0d want 16", rise_cnt - r0); end
    if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", timeout); end
    if (rx_data !== 8'hFF) begin errors++; $display("FAIL timeout_rx_data: got %h want ff", rx_data); end
    if (fin_cnt - f0 !== 1) begin errors++; $display("FAIL timeout_fin: got %0d want 1", fin_cnt - f0); end
    if (rxv_cnt - v0 !== 0) begin errors++; $display("FAIL timeout_no_rxv: got %0d want 0", rxv_cnt - v0); end
  endtask

  task automatic test_token_read();
    int v0, nf0, m0, f0, s0;
    divider = 8'd0; mode = 2'd3; count = 10'd511; poll_max = 16'd63;
    load_bits(64'hFE, 8);
    v0 = rxv_cnt; nf0 = rxv_not_ff; m0 = mosi_low_cnt; f0 = fin_cnt; s0 = strobe_cnt;
    pulse_start();
    wait_fin(f0, 20000, "token_done");
    step();
    checks += 6;
    if (rxv_cnt - v0 !== 512) begin errors++; $display("FAIL token_words: got %0d want 512", rxv_cnt - v0); end
    if (rxv_not_ff - nf0 !== 0) begin errors++; $display("FAIL token_data_ff: %0d words not ff, want 0", rxv_not_ff - nf0); end
    if (mosi_low_cnt - m0 !== 0) begin errors++; $display("FAIL token_mosi_high: %0d low cycles, want 0", mosi_low_cnt - m0); end
    if (crc16 !== 16'h7FA1) begin errors++; $display("FAIL token_crc16: got %h want 7fa1", crc16); end
    if (timeout !== 1'b0) begin errors++; $display("FAIL token_timeout_cleared: got %b want 0", timeout); end
    if (strobe_cnt - s0 !== 4096) begin errors++; $display("FAIL token_strobes: got %0d want 4096", strobe_cnt - s0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [0:3];
    int idx, r0, t0, f0, v0, n;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h00;
    divider = 8'd1; mode = 2'd1; count = 10'd2;
    load_bits(64'd0, 0);
    idx = 0; tx_data = words[0];
    r0 = rise_cnt; t0 = txreq_cnt; f0 = fin_cnt; v0 = rxv_cnt;
    pulse_start();
    n = 0;
    while (fin_cnt == f0 && n < 500) begin
      if (tx_req && idx < 3) begin
        idx++;
        tx_data = words[idx];
      end
      start = (n == 10 || n == 40);
      mode  = 2'd0;
      step();
      n++;
    end
    start = 1'b0;
    checks++;
    if (fin_cnt == f0) begin errors++; $display("FAIL burst_done: finished not seen within 500 cycles"); end
    repeat (4) step();
    checks += 5;
    if (txreq_cnt - t0 !== 3) begin errors++; $display("FAIL burst_tx_req: got %0d want 3", txreq_cnt - t0); end
    if (rise_cnt - r0 !== 24) begin errors++; $display("FAIL burst_bits: got %0d want 24", rise_cnt - r0); end
    if (mosi_hist[23:0] !== 24'h112233) begin errors++; $display("FAIL burst_mosi_stream: got %h want 112233", mosi_hist[23:0]); end
    if (fin_cnt - f0 !== 1) begin errors++; $display("FAIL burst_start_ignored: fin %0d want 1", fin_cnt - f0); end
    if (rxv_cnt - v0 !== 3) begin errors++; $display("FAIL burst_rx_valid: got %0d want 3", rxv_cnt - v0); end
  endtask

  task automatic test_reset_mid_burst();
    int r0, n;
    divider = 8'd2; mode = 2'd1; count = 10'd2; tx_data = 8'h5A;
    r0 = rise_cnt;
    pulse_start();
    n = 0;
    while (!(sclk && rise_cnt - r0 >= 5) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (!sclk) begin errors++; $display("FAIL rst_mid_setup: sclk high not reached, got %b", sclk); end
    #1 rst = 1'b1;
    #1;
    checks += 3;
    if (sclk !== 1'b0) begin errors++; $display("FAIL rst_mid_sclk: got %b want 0", sclk); end
    if (mosi !== 1'b1) begin errors++; $display("FAIL rst_mid_mosi: got %b want 1", mosi); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    step();
    rst = 1'b0;
    repeat (2) step();
    checks += 2;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_rx_data: got %h want 00", rx_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: busy %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_poll_match();
    test_abort();
    test_poll_timeout();
    test_token_read();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdcard_spi_xfer.md
Name: sdcard_spi_xfer

Overview:
Parametrised SD-card SPI transfer engine (SPI mode 0) between the SD command/data sequencers and the card pins. Supports single-word exchange, multi-word bursts with per-word handshakes, polling for a response whose MSB is 0, and token-wait-then-burst sector reads. Includes a bit-serial CRC16 over the burst data phase and keeps the per-bit CRC tap (crc_bit/crc_strobe) for the external CRC7 unit.

Parameters:
DATA_W, 8, bits per word
DIV_W, 8, width of divider input
CNT_W, 10, width of burst word count (count+1 words)
POLL_W, 16, width of poll bit limit

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
sclk  out  1  SPI clock, idle low
mosi  out  1  SPI data out, idle high
miso  in  1  SPI data in
divider  in  DIV_W  SCLK half-period in clk cycles; 0 is treated as 1
mode  in  2  0=single, 1=burst write, 2=poll response, 3=token-wait read
count  in  CNT_W  burst words minus 1 (modes 1, 3)
poll_max  in  POLL_W  poll bit limit minus 1 (modes 2, 3)
tx_data  in  DATA_W  word to send, sampled at each load
start  in  1  start pulse, honoured only when idle
abort  in  1  synchronous abort
tx_req  out  1  1-cycle pulse: tx_data loaded, present next word
rx_data  out  DATA_W  last received word
rx_valid  out  1  1-cycle pulse: rx_data updated with a valid word
busy  out  1  transfer in progress
finished  out  1  1-cycle pulse on normal completion or timeout
timeout  out  1  sticky until next start: poll limit reached
crc16  out  16  CRC-CCITT (x^16+x^12+x^5+1, init 0) of burst data bits
crc_bit  out  1  current data bit for external CRC
crc_strobe  out  1  1-cycle pulse qualifying crc_bit

Behaviour:
- Reset (async): sclk=0, mosi=1, busy=0, rx_data=0, all pulses 0, timeout=0, crc16=0, state IDLE.
- Clock divider: sclk toggles every max(divider,1) clk cycles while busy. Rising edge latches miso. Falling edge shifts rx and advances mosi. The first rising edge occurs max(divider,1) cycles after start.
- States: IDLE, POLL, XFER.
- IDLE with start:
  - Modes 0/1: load tx_data, mosi=tx_data[MSB], pulse tx_req, go to XFER.
  - Modes 2/3: mosi held 1, go to POLL.
  - Every start clears timeout and crc16 and presets the rx shift register to all ones.
- POLL: each falling edge counts one bit.
  - Mode 2: if the last-DATA_W-bit window has MSB=0, set rx_data=window, pulse rx_valid, pulse finished, go to IDLE.
  - Mode 3: if the received bit is 0, go to XFER with mosi=1 for all words.
  - If poll_max+1 bits are clocked without a match: timeout=1, rx_data=window, pulse finished, no rx_valid, go to IDLE.
- XFER: after DATA_W falling edges, rx_data=word and rx_valid pulses.
  - If words remain (modes 1/3, count+1 total): mode 1 loads tx_data and pulses tx_req in the same cycle; mode 3 keeps mosi=1.
  - Otherwise pulse finished, busy=0, mosi=1.
  - Upstream must present the next word within one word time after tx_req.
- CRC:
  - crc_strobe pulses on every XFER falling edge, and on every POLL falling edge in mode 2.
  - crc_bit is the transmitted bit in modes 0/1 and the received bit in modes 2/3.
  - crc16 is updated only in XFER for modes 1 and 3.
- sclk is always low when busy falls.
- abort: next cycle state=IDLE, sclk=0, mosi=1, busy=0. No finished, no rx_valid, rx_data unchanged.
- start while busy is ignored. abort and start in the same cycle: abort wins.
- A divider change mid-transfer takes effect at the next half-period.

Decomposition:
- Shared package sdcard_pkg: mode encodings (MODE_SINGLE, MODE_BURST_WR, MODE_POLL, MODE_TOKEN_RD) and CRC16 polynomial constant 16'h1021.
- One sub-module: sdcard_crc16, a bit-serial CRC16 with clear, enable and bit inputs, reused by the data sequencer.

Test Plan:
1. divider=0, mode 0, tx_data=8'hA5, miso looped to mosi -> 8 sclk rising edges; rx_data=8'hA5; rx_valid and finished pulse together; sclk=0 afterwards.
2. divider=3, mode 2, poll_max=63, miso returns 13 ones then 8'h01 -> finished after 21 bits; rx_data=8'h01; rx_valid=1; timeout=0; sclk half-period 3 cycles.
3. mode 2, poll_max=15, miso stuck 1 -> exactly 16 rising edges; timeout=1; rx_data=8'hFF; finished pulses; rx_valid never pulses.
4. mode 3, count=511, miso gives 7 ones, a 0, then 512 bytes of 8'hFF -> 512 rx_valid pulses all 8'hFF; mosi constantly 1; crc16=16'h7FA1.
5. mode 1, count=2, tx words 8'h11, 8'h22, 8'h33 -> 3 tx_req pulses; mosi bit stream 0x11 0x22 0x33 MSB first; start pulses during the transfer are ignored.
6. Mid-transfer cases:
   - abort during mode 2 poll -> idle next cycle, no finished.
   - rst asserted mid-burst -> sclk=0, mosi=1, busy=0 immediately, without waiting for a clk edge.
